// File: rtl/ml_kem_sample_ntt.sv
// SampleNTT rejection sampler: parses SHAKE128 squeeze blocks into 12-bit candidates and
// streams the 256 accepted coefficients (< Q) of one polynomial through a valid/ready output.
module ml_kem_sample_ntt #(
   parameter int unsigned ML_KEM_Q     = 3329,
   parameter int unsigned ML_KEM_LEN_Q = 12,
   parameter int unsigned N_COEF       = 256,
   parameter int unsigned RATE_BYTES   = 168
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      blk_valid_i,
   output logic                      blk_ready_o,
   input  logic [RATE_BYTES*8-1:0]   blk_i,
   output logic                      coef_valid_o,
   input  logic                      coef_ready_i,
   output logic [ML_KEM_LEN_Q-1:0]   coef_o,
   output logic [$clog2(N_COEF)-1:0] coef_idx_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int unsigned BlkW     = RATE_BYTES * 8;
   localparam int unsigned Triplets = RATE_BYTES / 3;
   localparam int unsigned PtrW     = $clog2(Triplets);
   localparam int unsigned BaseW    = $clog2(BlkW);
   localparam int unsigned IdxW     = $clog2(N_COEF);
   localparam int unsigned CntW     = IdxW + 1;

   typedef enum logic [2:0] {StIdle, StWaitBlk, StParse, StDrain, StDone} state_e;

   state_e                  state_q, state_d;
   logic [BlkW-1:0]         blk_q, blk_d;
   logic [PtrW-1:0]         ptr_q, ptr_d;
   logic                    phase_q, phase_d;
   logic [CntW-1:0]         count_q, count_d;
   logic [ML_KEM_LEN_Q-1:0] coef_q, coef_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    valid_q, valid_d;

   logic [BaseW-1:0]        base;
   logic [23:0]             trip;
   logic [ML_KEM_LEN_Q-1:0] cand;
   logic                    free;
   logic                    accept;

   always_comb begin
      base   = BaseW'(ptr_q) * BaseW'(24);
      trip   = blk_q[base +: 24];
      // phase 0: b0 | b1[3:0] << 8, phase 1: b1[7:4] | b2 << 4
      cand   = phase_q ? {trip[23:16], trip[15:12]} : {trip[11:8], trip[7:0]};
      free   = !valid_q || coef_ready_i;
      accept = cand < ML_KEM_LEN_Q'(ML_KEM_Q);
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      ptr_d   = ptr_q;
      phase_d = phase_q;
      count_d = count_q;
      coef_d  = coef_q;
      idx_d   = idx_q;
      valid_d = valid_q && !coef_ready_i;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               count_d = '0;
               state_d = StWaitBlk;
            end
         end
         StWaitBlk: begin
            if (blk_valid_i) begin
               blk_d   = blk_i;
               ptr_d   = '0;
               phase_d = 1'b0;
               state_d = StParse;
            end
         end
         StParse: begin
            if (free) begin
               if (accept) begin
                  coef_d  = cand;
                  idx_d   = count_q[IdxW-1:0];
                  valid_d = 1'b1;
                  count_d = count_q + 1'b1;
               end
               // The final load ends parsing at once; leftover candidates are dropped.
               if (accept && count_q == CntW'(N_COEF - 1)) begin
                  state_d = StDrain;
               end else begin
                  phase_d = !phase_q;
                  if (phase_q) begin
                     ptr_d = ptr_q + 1'b1;
                     if (ptr_q == PtrW'(Triplets - 1)) begin
                        state_d = StWaitBlk;
                     end
                  end
               end
            end
         end
         StDrain: begin
            if (!valid_q || coef_ready_i) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         phase_q <= 1'b0;
         count_q <= '0;
         coef_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         phase_q <= phase_d;
         count_q <= count_d;
         coef_q  <= coef_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   // Block data is only read in PARSE, which is always preceded by a fresh capture.
   always_ff @(posedge clk) begin
      blk_q <= blk_d;
   end

   assign blk_ready_o  = (state_q == StWaitBlk);
   assign busy_o       = (state_q != StIdle);
   assign done_o       = (state_q == StDone);
   assign coef_valid_o = valid_q;
   assign coef_o       = coef_q;
   assign coef_idx_o   = idx_q;

endmodule

// File: tb/tb_ml_kem_sample_ntt.sv
// Directed bench for ml_kem_sample_ntt: hand-computed coefficient streams, stalls, reset and
// ignored-input cases.
module tb_ml_kem_sample_ntt;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          blk_valid_i;
   logic          blk_ready_o;
   logic [1343:0] blk_i;
   logic          coef_valid_o;
   logic          coef_ready_i;
   logic [11:0]   coef_o;
   logic [7:0]    coef_idx_o;
   logic          busy_o;
   logic          done_o;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ml_kem_sample_ntt dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .blk_valid_i  (blk_valid_i),
      .blk_ready_o  (blk_ready_o),
      .blk_i        (blk_i),
      .coef_valid_o (coef_valid_o),
      .coef_ready_i (coef_ready_i),
      .coef_o       (coef_o),
      .coef_idx_o   (coef_idx_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1343:0] pat3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
      logic [1343:0] r;
      for (int k = 0; k < 168; k++) r[8*k +: 8] = (k % 3 == 0) ? a : ((k % 3 == 1) ? b : c);
      return r;
   endfunction

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!blk_ready_o && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(blk_ready_o), 32'd1);
   endtask

   task automatic capture(input logic [1343:0] b);
      blk_i       = b;
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [1343:0] blk_a;
      logic [1343:0] blk_b;
      int got, errs, sent, dones, n, vseen;

      rst          = 1'b1;
      start_i      = 1'b0;
      blk_valid_i  = 1'b0;
      blk_i        = '0;
      coef_ready_i = 1'b1;
      blk_a        = pat3(8'h01, 8'h23, 8'h45);
      tick();
      tick();
      check("rst_valid", 32'(coef_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_blk_ready", 32'(blk_ready_o), 32'd0);
      check("rst_coef", 32'(coef_o), 32'd0);
      check("rst_idx", 32'(coef_idx_o), 32'd0);
      rst = 1'b0;
      tick();

      // 1: 769/1106 pairs, all accepted, 112+112+32 over three blocks
      do_start();
      got = 0; errs = 0; sent = 0; dones = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (coef_valid_o) begin
            if (coef_idx_o != 8'(got) || coef_o != ((got % 2 == 0) ? 12'd769 : 12'd1106)) errs++;
            got++;
         end
         if (done_o) dones++;
         if (!busy_o && dones > 0) break;
         blk_i       = blk_a;
         blk_valid_i = blk_ready_o && (sent < 3);
         if (blk_valid_i) sent++;
         tick();
      end
      blk_valid_i = 1'b0;
      check("t1_seq_errs", 32'(errs), 32'd0);
      check("t1_coef_count", 32'(got), 32'd256);
      check("t1_blocks", 32'(sent), 32'd3);
      check("t1_done_pulses", 32'(dones), 32'd1);
      check("t1_idle_busy", 32'(busy_o), 32'd0);
      check("t1_idle_blk_ready", 32'(blk_ready_o), 32'd0);

      // 2: all-0xFF block rejects every candidate
      do_start();
      wait_ready("t2_ready");
      capture({168{8'hFF}});
      n = 0; vseen = 0;
      while (!blk_ready_o && n < 200) begin
         if (coef_valid_o) vseen = 1;
         tick();
         n++;
      end
      check("t2_ready_cycles", 32'(n), 32'd112);
      check("t2_no_valid", 32'(vseen), 32'd0);
      do_reset();

      // 3: boundary values 3328 accepted, 3329 rejected, 0 accepted
      blk_b = {168{8'hFF}};
      blk_b[23:0]  = 24'hD00D00;
      blk_b[47:24] = 24'h000D01;
      do_start();
      wait_ready("t3_ready");
      capture(blk_b);
      check("t3_lat_valid0", 32'(coef_valid_o), 32'd0);
      tick();
      check("t3_c0_valid", 32'(coef_valid_o), 32'd1);
      check("t3_c0_coef", 32'(coef_o), 32'd3328);
      check("t3_c0_idx", 32'(coef_idx_o), 32'd0);
      tick();
      check("t3_c1_coef", 32'(coef_o), 32'd3328);
      check("t3_c1_idx", 32'(coef_idx_o), 32'd1);
      tick();
      check("t3_reject_valid", 32'(coef_valid_o), 32'd0);
      tick();
      check("t3_c2_valid", 32'(coef_valid_o), 32'd1);
      check("t3_c2_coef", 32'(coef_o), 32'd0);
      check("t3_c2_idx", 32'(coef_idx_o), 32'd2);
      tick();
      check("t3_tail_valid", 32'(coef_valid_o), 32'd0);
      do_reset();

      // 4: downstream stall for 10 cycles mid-block
      do_start();
      wait_ready("t4_ready");
      capture(blk_a);
      for (int i = 0; i < 5; i++) tick();
      check("t4_pre_idx", 32'(coef_idx_o), 32'd4);
      check("t4_pre_coef", 32'(coef_o), 32'd769);
      coef_ready_i = 1'b0;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!coef_valid_o || coef_o != 12'd769 || coef_idx_o != 8'd4) errs++;
      end
      check("t4_stall_stable_errs", 32'(errs), 32'd0);
      coef_ready_i = 1'b1;
      errs = 0;
      for (int i = 5; i < 25; i++) begin
         tick();
         if (!coef_valid_o || coef_idx_o != 8'(i) ||
             coef_o != ((i % 2 == 0) ? 12'd769 : 12'd1106)) errs++;
      end
      check("t4_resume_seq_errs", 32'(errs), 32'd0);
      do_reset();

      // 5: reset in the middle of parsing at count 100
      do_start();
      wait_ready("t5_ready");
      capture(blk_a);
      n = 0;
      while (!(coef_valid_o && coef_idx_o == 8'd99) && n < 200) begin
         tick();
         n++;
      end
      check("t5_reached_idx99", 32'(coef_idx_o), 32'd99);
      do_reset();
      check("t5_rst_valid", 32'(coef_valid_o), 32'd0);
      check("t5_rst_coef", 32'(coef_o), 32'd0);
      check("t5_rst_idx", 32'(coef_idx_o), 32'd0);
      check("t5_rst_busy", 32'(busy_o), 32'd0);
      check("t5_rst_done", 32'(done_o), 32'd0);
      check("t5_rst_blk_ready", 32'(blk_ready_o), 32'd0);
      do_start();
      wait_ready("t5_restart_ready");
      capture(blk_a);
      tick();
      check("t5_restart_idx", 32'(coef_idx_o), 32'd0);
      check("t5_restart_coef", 32'(coef_o), 32'd769);

      // 6: start_i and a competing block during PARSE are both ignored
      start_i     = 1'b1;
      blk_valid_i = 1'b1;
      blk_i       = '0;
      tick();
      check("t6_blk_ready_low", 32'(blk_ready_o), 32'd0);
      check("t6_c1_idx", 32'(coef_idx_o), 32'd1);
      check("t6_c1_coef", 32'(coef_o), 32'd1106);
      start_i     = 1'b0;
      blk_valid_i = 1'b0;
      tick();
      check("t6_c2_idx", 32'(coef_idx_o), 32'd2);
      check("t6_c2_coef", 32'(coef_o), 32'd769);
      tick();
      check("t6_c3_idx", 32'(coef_idx_o), 32'd3);
      check("t6_c3_coef", 32'(coef_o), 32'd1106);
      check("t6_busy", 32'(busy_o), 32'd1);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
